// File: rtl/clb_cfg_segment_if.sv
// Chain-side signal bundle of one configuration segment tile.
// The tile sits on the slave modport; upstream logic or the previous tile drives the master side.
interface clb_cfg_segment_if #(
    parameter int CFG_BITS = 64,
    parameter int LANES    = 1
);
    localparam int DEPTH = CFG_BITS / LANES;
    localparam int CW    = $clog2(DEPTH + 1);

    // The chain has no valid/ready handshake. cen qualifies shift_in_hard in
    // the same cycle. set/capture are one-cycle pulses. Every output is a
    // flop, so a tile never stalls its neighbours.
    logic                cen;
    logic [LANES-1:0]    shift_in_hard;
    logic [LANES-1:0]    shift_out_hard;
    logic                set_in_hard;
    logic                set_out_hard;
    logic                capture_in_hard;
    logic                capture_out_hard;
    logic [CFG_BITS-1:0] cfg_out;
    logic                cfg_valid;
    logic                frame_err;
    logic [CW-1:0]       cnt_dbg;

    modport master (
        output cen, shift_in_hard, set_in_hard, capture_in_hard,
        input  shift_out_hard, set_out_hard, capture_out_hard,
        input  cfg_out, cfg_valid, frame_err, cnt_dbg
    );

    modport slave (
        input  cen, shift_in_hard, set_in_hard, capture_in_hard,
        output shift_out_hard, set_out_hard, capture_out_hard,
        output cfg_out, cfg_valid, frame_err, cnt_dbg
    );
endinterface

// File: rtl/clb_cfg_segment.sv
// Per-tile configuration segment: a LANES-wide shift chain, a shadow commit register with frame-length check,
// readback capture, and registered set/capture pass-through for daisy-chaining.
module clb_cfg_segment #(
    parameter int CFG_BITS = 64,
    parameter int LANES    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    clb_cfg_segment_if.slave      bus
);
    localparam int            DEPTH   = CFG_BITS / LANES;
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CFG_BITS-1:0] sr_q, sr_d;
    logic [CFG_BITS-1:0] sh_q, sh_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                set_q, cap_q;
    logic [CFG_BITS-1:0] shifted;

    generate
        if (DEPTH > 1) begin : g_deep
            assign shifted = {sr_q[CFG_BITS-LANES-1:0], bus.shift_in_hard};
        end else begin : g_single
            assign shifted = bus.shift_in_hard;
        end
    endgenerate

    always_comb begin
        sr_d    = sr_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (bus.set_in_hard) begin
            // Commit the pre-shift contents. The frame counter restarts either way.
            if (cnt_q == DEPTH_C) begin
                sh_d    = sr_q;
                valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            cnt_d = CW'(bus.cen);
            if (bus.cen) sr_d = shifted;
        end else if (bus.capture_in_hard) begin
            sr_d  = sh_q;
            cnt_d = '0;
        end else if (bus.cen) begin
            sr_d  = shifted;
            cnt_d = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            set_q   <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            set_q   <= bus.set_in_hard;
            cap_q   <= bus.capture_in_hard;
        end
    end

    assign bus.shift_out_hard   = sr_q[CFG_BITS-1 -: LANES];
    assign bus.set_out_hard     = set_q;
    assign bus.capture_out_hard = cap_q;
    assign bus.cfg_out          = sh_q;
    assign bus.cfg_valid        = valid_q;
    assign bus.frame_err        = err_q;
    assign bus.cnt_dbg          = cnt_q;
endmodule

// File: tb/tb_clb_cfg_segment.sv
// Bench for clb_cfg_segment: a table-driven 8-bit tile, hand sequences for readback, reset,
// a two-tile daisy chain and a 4-lane tile.
module tb_clb_cfg_segment;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clb_cfg_segment_if #(.CFG_BITS(8),  .LANES(1)) if8 ();
  clb_cfg_segment_if #(.CFG_BITS(8),  .LANES(1)) ifa ();
  clb_cfg_segment_if #(.CFG_BITS(8),  .LANES(1)) ifb ();
  clb_cfg_segment_if #(.CFG_BITS(16), .LANES(4)) if16 ();

  clb_cfg_segment #(.CFG_BITS(8),  .LANES(1)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  clb_cfg_segment #(.CFG_BITS(8),  .LANES(1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  clb_cfg_segment #(.CFG_BITS(8),  .LANES(1)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));
  clb_cfg_segment #(.CFG_BITS(16), .LANES(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  // The downstream tile sees the upstream tile's registered outputs; cen is broadcast.
  assign ifb.cen             = ifa.cen;
  assign ifb.shift_in_hard   = ifa.shift_out_hard;
  assign ifb.set_in_hard     = ifa.set_out_hard;
  assign ifb.capture_in_hard = ifa.capture_out_hard;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [7:0]   sh_model;

  typedef struct {
    logic       cen;
    logic       din;
    logic       set;
    logic       cap;
    logic [7:0] cfg;
    logic       valid;
    logic       err;
    logic       sout;
    logic       set_o;
    logic       cap_o;
    logic [3:0] cnt;
  } vec_t;
  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if8.cen = 1'b0; if8.shift_in_hard = '0; if8.set_in_hard = 1'b0; if8.capture_in_hard = 1'b0;
    ifa.cen = 1'b0; ifa.shift_in_hard = '0; ifa.set_in_hard = 1'b0; ifa.capture_in_hard = 1'b0;
    if16.cen = 1'b0; if16.shift_in_hard = '0; if16.set_in_hard = 1'b0; if16.capture_in_hard = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive8(input logic cen, input logic din, input logic set, input logic cap);
    if8.cen = cen; if8.shift_in_hard = din; if8.set_in_hard = set; if8.capture_in_hard = cap;
  endtask

  task automatic chk_all_zero8(input string tag);
    chk({tag, "_cfg"},   if8.cfg_out, 0);
    chk({tag, "_sout"},  if8.shift_out_hard, 0);
    chk({tag, "_set_o"}, if8.set_out_hard, 0);
    chk({tag, "_cap_o"}, if8.capture_out_hard, 0);
    chk({tag, "_valid"}, if8.cfg_valid, 0);
    chk({tag, "_err"},   if8.frame_err, 0);
    chk({tag, "_cnt"},   if8.cnt_dbg, 0);
  endtask

  initial begin
    // Load A5 MSB first, commit, then an underflowing 5-bit frame of zeros.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};

    do_reset();
    chk_all_zero8("reset");
    chk("reset_cfg16", if16.cfg_out, 0);

    for (int i = 0; i < 17; i++) begin
      drive8(vecs[i].cen, vecs[i].din, vecs[i].set, vecs[i].cap);
      tick();
      chk($sformatf("v%0d_cfg", i),   if8.cfg_out,          vecs[i].cfg);
      chk($sformatf("v%0d_valid", i), if8.cfg_valid,        vecs[i].valid);
      chk($sformatf("v%0d_err", i),   if8.frame_err,        vecs[i].err);
      chk($sformatf("v%0d_sout", i),  if8.shift_out_hard,   vecs[i].sout);
      chk($sformatf("v%0d_set_o", i), if8.set_out_hard,     vecs[i].set_o);
      chk($sformatf("v%0d_cap_o", i), if8.capture_out_hard, vecs[i].cap_o);
      chk($sformatf("v%0d_cnt", i),   if8.cnt_dbg,          vecs[i].cnt);
    end
    sh_model = 8'hA5;

    // Readback: capture (with a shift that must be ignored), then clock out SH with zeros.
    drive8(1'b1, 1'b1, 1'b0, 1'b1);
    for (int b = 7; b >= 0; b--) exp_q.push_back(W'(sh_model[b]));
    tick();
    exp_v = exp_q.pop_front();
    chk("rb_cap_bit", if8.shift_out_hard, exp_v);
    chk("rb_cap_o", if8.capture_out_hard, 1);
    chk("rb_cap_cnt", if8.cnt_dbg, 0);
    for (int i = 0; i < 8; i++) begin
      drive8(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        chk($sformatf("rb_bit%0d", i + 1), if8.shift_out_hard, exp_v);
      end else begin
        chk("rb_tail", if8.shift_out_hard, 0);
      end
      chk($sformatf("rb_cfg%0d", i), if8.cfg_out, sh_model);
    end

    // Set and capture together: set wins, SR (now all zero) is committed, capture only forwarded.
    drive8(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    sh_model = 8'h00;
    chk("sc_cfg", if8.cfg_out, sh_model);
    chk("sc_sout", if8.shift_out_hard, 0);
    chk("sc_set_o", if8.set_out_hard, 1);
    chk("sc_cap_o", if8.capture_out_hard, 1);
    chk("sc_cnt", if8.cnt_dbg, 0);
    chk("sc_valid", if8.cfg_valid, 1);

    // Reset mid-frame overrides a simultaneous shift and set.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive8(1'b1, 1'(i % 2 == 0), 1'b0, 1'b0);
      tick();
    end
    drive8(1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero8("midrst");
    for (int i = 0; i < 8; i++) begin
      drive8(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive8(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive8(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_cfg", if8.cfg_out, 8'hFF);
    chk("midrst_err", if8.frame_err, 0);
    chk("midrst_valid", if8.cfg_valid, 1);

    // Daisy chain: 0x3C then 0xA5 MSB first; the upstream tile keeps the last 8 bits.
    do_reset();
    begin
      logic [15:0] stream;
      stream = 16'h3CA5;
      exp_q.push_back(W'(stream[7:0]));
      exp_q.push_back(W'(stream[15:8]));
      for (int i = 15; i >= 0; i--) begin
        ifa.cen = 1'b1;
        ifa.shift_in_hard = stream[i];
        tick();
      end
    end
    ifa.cen = 1'b0;
    ifa.shift_in_hard = '0;
    ifa.set_in_hard = 1'b1;
    tick();
    ifa.set_in_hard = 1'b0;
    exp_v = exp_q.pop_front();
    chk("dc_a_cfg", ifa.cfg_out, exp_v);
    chk("dc_b_cfg_early", ifb.cfg_out, 0);
    tick();
    exp_v = exp_q.pop_front();
    chk("dc_b_cfg", ifb.cfg_out, exp_v);
    chk("dc_a_err", ifa.frame_err, 0);
    chk("dc_b_err", ifb.frame_err, 0);
    chk("dc_b_valid", ifb.cfg_valid, 1);

    // Four lanes with stalls between words.
    do_reset();
    for (int w = 1; w <= 4; w++) begin
      if16.cen = 1'b1;
      if16.shift_in_hard = 4'(w);
      tick();
      if16.cen = 1'b0;
      if16.shift_in_hard = 4'($urandom_range(0, 15));
      for (int s = 0; s < 3; s++) tick();
    end
    chk("ln_sout", if16.shift_out_hard, 4'h1);
    chk("ln_cnt", if16.cnt_dbg, 4);
    exp_q.push_back(W'(16'h1234));
    if16.set_in_hard = 1'b1;
    tick();
    if16.set_in_hard = 1'b0;
    exp_v = exp_q.pop_front();
    chk("ln_cfg", if16.cfg_out, exp_v);
    chk("ln_err", if16.frame_err, 0);
    chk("ln_valid", if16.cfg_valid, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clb_cfg_segment.md
# clb_cfg_segment

Parametrised per-tile configuration segment for the fabric's hard configuration chain. It generalises the single-bit shift/set chain of a CLB tile to LANES parallel shift lanes and a CFG_BITS-deep frame. It adds a shadow register with frame-length checking, a registered set/capture pass-through for daisy-chaining, and readback of the active configuration. One instance sits in each tile between the chain input and the tile's configuration consumers (LUT masks, switch-box and connection-box selects).

## Interface
- CFG_BITS, 64, configuration bits held by this tile; must be a multiple of LANES
- LANES, 1, shift lanes per cycle; chain depth DEPTH = CFG_BITS/LANES
- clk  input  1  fabric clock
- rst  input  1  synchronous, active-high reset
- cen  input  1  shift enable; one lane word shifts per cycle while high
- shift_in_hard  input  LANES  chain data from upstream tile
- shift_out_hard  output  LANES  chain data to downstream tile, = SR[CFG_BITS-1 -: LANES]
- set_in_hard  input  1  commit request, one-cycle pulse
- set_out_hard  output  1  set_in_hard delayed one cycle
- capture_in_hard  input  1  readback request, one-cycle pulse
- capture_out_hard  output  1  capture_in_hard delayed one cycle
- cfg_out  output  CFG_BITS  active configuration (shadow register)
- cfg_valid  output  1  at least one good commit since reset
- frame_err  output  1  sticky: a commit was attempted with fewer than DEPTH shifts

## Operation
- State: shift register SR[CFG_BITS-1:0], shadow SH[CFG_BITS-1:0], shift counter cnt (0..DEPTH, saturating), flags cfg_valid and frame_err, pass-through flops for set and capture.
- Shift (cen=1): SR <= {SR[CFG_BITS-LANES-1:0], shift_in_hard}; cnt <= min(cnt+1, DEPTH). The first word shifted ends at the top of SR. With LANES=1 the chain is MSB first.
- Saturation: cnt stays at DEPTH on extra shifts. Overflow is legal because downstream tiles' data passes through this tile.
- Set (set_in_hard=1) has priority over capture and shift:
  - If cnt==DEPTH: SH <= SR (pre-shift value) and cfg_valid <= 1.
  - Otherwise: SH is unchanged and frame_err <= 1.
  - In both cases cnt <= (cen ? 1 : 0), and SR still shifts if cen=1.
- Capture (capture_in_hard=1, set_in_hard=0): SR <= SH and cnt <= 0. A shift in the same cycle is ignored. The next DEPTH shifts emit SH on shift_out_hard, top word first.
- Set and capture in the same cycle: set wins; capture is ignored locally but still forwarded on capture_out_hard.
- cen=0 with no set/capture: all state holds.
- frame_err clears only on rst. cfg_valid is never cleared by a failed commit.
- cfg_out = SH, driven directly from the register with no combinational path from inputs.

## Timing
- Reset values: SR=0, SH=0 (all tile resources inert), cnt=0, cfg_out=0, shift_out_hard=0, set_out_hard=0, capture_out_hard=0, cfg_valid=0, frame_err=0.
- Reset takes effect at the clock edge and overrides cen, set and capture in that cycle. Reset mid-shift discards the partial frame.
- shift_out_hard is registered. A word presented at shift cycle k appears on shift_out_hard after shift cycle k+DEPTH-1, i.e. DEPTH shift cycles of latency per tile.
- set_out_hard and capture_out_hard follow their inputs with exactly one cycle of latency, independent of cen. Commit therefore ripples one tile per cycle down the chain.
- cfg_out, cfg_valid and frame_err update on the edge that samples set_in_hard, and are visible the following cycle.
- Combinational input-to-output paths: none.

## Test plan
- CFG_BITS=8, LANES=1: shift bits 1,0,1,0,0,1,0,1, then pulse set → cfg_out=0xA5 and cfg_valid=1 the next cycle; set_out_hard high one cycle after set_in_hard.
- Underflow: after a good commit of 0xA5, shift 5 bits and set → frame_err=1, cfg_out stays 0xA5, cfg_valid stays 1, cnt resets.
- Daisy chain: two instances (CFG_BITS=8) chained, shift 0x3C then 0xA5 (16 bits), then set → first tile cfg_out=0xA5, downstream tile cfg_out=0x3C one cycle later; neither raises frame_err.
- Lanes and stalls: CFG_BITS=16, LANES=4, shift words 0x1,0x2,0x3,0x4 with cen low for 3 cycles between words, then set → cfg_out=0x1234.
- Readback: after committing 0xA5, pulse capture, then shift 8 zeros → shift_out_hard emits 1,0,1,0,0,1,0,1 and cfg_out remains 0xA5; set and capture asserted together → set behaviour only, capture_out_hard still pulses.
- Reset mid-operation: assert rst after 4 of 8 shifts, then shift 8 bits of 0xFF and set → cfg_out=0xFF, frame_err=0; all outputs read 0 in the cycle after rst.
